mem_arbiter: RTL and testbench

- Sits between the per-core cache controllers and the RAM port of the multicore top.
- Arbitrates instruction and data requests from CPUS cores onto the single RAM request bus (address, store data, REN, WEN).
- Holds each granted request until RAM reports ACCESS, then returns the load data and the wait-release to the owning source.
- Round-robin across cores; data has priority over instruction within a core. No coherence: a pure request arbiter.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_picker.sv | 38 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared RAM/arbiter types for the multicore memory path
// Revision      : 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of a core index; a single-core build still needs a 1-bit field.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational rotate-priority select starting at index i_rr
// Revision  : 1.0
// ============================================================================
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int RRW  = rr_width(CPUS)
) (
  input  logic [CPUS-1:0] i_req,
  input  logic [RRW-1:0]  i_rr,
  output logic            o_valid,
  output logic [RRW-1:0]  o_winner
);

  int             w_idx;
  logic [RRW-1:0] w_sel;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    w_sel    = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      w_idx = (int'(i_rr) + k) % CPUS;
      w_sel = RRW'(w_idx);
      if (i_req[w_sel]) begin
        o_valid  = 1'b1;
        o_winner = w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin I/D request arbiter onto a single RAM port
// Revision    : 1.0
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*DATA_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*DATA_W-1:0]   iload,
  output logic [CPUS*DATA_W-1:0]   dload,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [DATA_W-1:0]        ramload,
  input  ramstate_t                ramstate
);

  localparam int             RRW          = rr_width(CPUS);
  localparam logic [RRW-1:0] c_LAST_CORE  = RRW'(CPUS - 1);

  arb_state_t       r_state;
  logic [RRW-1:0]   r_rr;
  logic [RRW-1:0]   r_own_core;
  logic             r_own_data;
  logic             r_own_write;

  logic [CPUS-1:0]   w_req;
  logic              w_valid;
  logic [RRW-1:0]    w_winner;
  logic [ADDR_W-1:0] w_iaddr  [CPUS];
  logic [ADDR_W-1:0] w_daddr  [CPUS];
  logic [DATA_W-1:0] w_dstore [CPUS];
  logic              w_grant;
  logic              w_own_act;
  logic              w_done;

  rr_picker #(
    .CPUS (CPUS),
    .RRW  (RRW)
  ) u_picker (
    .i_req    (w_req),
    .i_rr     (r_rr),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  // Reset gates every RAM-facing and core-facing output combinationally.
  assign w_grant   = nRST && (r_state == ARB_GRANT);
  assign w_own_act = w_grant && (r_own_data ? (dREN[r_own_core] | dWEN[r_own_core])
                                            : iREN[r_own_core]);
  assign w_done    = w_own_act && (ramstate == ACCESS);

  assign ramREN   = w_own_act && !r_own_write;
  assign ramWEN   = w_own_act &&  r_own_write;
  assign ramaddr  = w_grant ? (r_own_data ? w_daddr[r_own_core] : w_iaddr[r_own_core]) : '0;
  assign ramstore = (w_grant && r_own_write) ? w_dstore[r_own_core] : '0;

  for (genvar c = 0; c < CPUS; c++) begin : g_core
    logic w_mine;

    assign w_iaddr[c]  = iaddr[c*ADDR_W +: ADDR_W];
    assign w_daddr[c]  = daddr[c*ADDR_W +: ADDR_W];
    assign w_dstore[c] = dstore[c*DATA_W +: DATA_W];
    assign w_req[c]    = iREN[c] | dREN[c] | dWEN[c];
    assign w_mine      = (r_own_core == RRW'(c));

    assign iwait[c] = !(w_done && w_mine && !r_own_data);
    assign dwait[c] = !(w_done && w_mine &&  r_own_data);
    assign iload[c*DATA_W +: DATA_W] = (w_done && w_mine && !r_own_data) ? ramload : '0;
    assign dload[c*DATA_W +: DATA_W] =
      (w_done && w_mine && r_own_data && !r_own_write) ? ramload : '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= ARB_IDLE;
      r_rr        <= '0;
      r_own_core  <= '0;
      r_own_data  <= 1'b0;
      r_own_write <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_state     <= ARB_GRANT;
            r_own_core  <= w_winner;
            r_own_data  <= dREN[w_winner] | dWEN[w_winner];
            r_own_write <= dWEN[w_winner];
          end
        end
        ARB_GRANT: begin
          // An owner that drops its request abandons the grant without moving rr.
          if (!w_own_act) begin
            r_state <= ARB_IDLE;
          end else if (w_done) begin
            r_state <= ARB_IDLE;
            r_rr    <= (r_own_core == c_LAST_CORE) ? '0 : r_own_core + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed + randomized bench against a transaction-level model
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [CPUS-1:0]      iREN, dREN, dWEN;
  logic [CPUS*AW-1:0]   iaddr, daddr;
  logic [CPUS*DW-1:0]   dstore;
  logic [CPUS-1:0]      iwait, dwait;
  logic [CPUS*DW-1:0]   iload, dload;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore;
  logic                 ramREN, ramWEN;
  logic [DW-1:0]        ramload;
  ramstate_t            ramstate;

  mem_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who (if anyone) currently holds the RAM port, and whose turn is next.
  bit m_busy;
  int m_core;
  bit m_data;
  bit m_write;
  int m_rr;
  logic [CPUS-1:0] e_done_i, e_done_d;
  int order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [CPUS-1:0]    ew_i, ew_d;
    logic [CPUS*DW-1:0] el_i, el_d;
    logic [AW-1:0]      ea;
    logic [DW-1:0]      es;
    logic               eren, ewen, act;
    ew_i = '1; ew_d = '1; el_i = '0; el_d = '0;
    ea = '0; es = '0; eren = 1'b0; ewen = 1'b0; act = 1'b0;
    if (nRST && m_busy) begin
      act  = m_data ? (dREN[m_core] | dWEN[m_core]) : iREN[m_core];
      ea   = m_data ? daddr[m_core*AW +: AW] : iaddr[m_core*AW +: AW];
      if (m_write) es = dstore[m_core*DW +: DW];
      eren = act && !m_write;
      ewen = act && m_write;
      if (act && ramstate == ACCESS) begin
        if (m_data) begin
          ew_d[m_core] = 1'b0;
          if (!m_write) el_d[m_core*DW +: DW] = ramload;
        end else begin
          ew_i[m_core] = 1'b0;
          el_i[m_core*DW +: DW] = ramload;
        end
      end
    end
    e_done_i = ~ew_i;
    e_done_d = ~ew_d;
    chk("ramREN", 64'(ramREN), 64'(eren));
    chk("ramWEN", 64'(ramWEN), 64'(ewen));
    chk("ramaddr", 64'(ramaddr), 64'(ea));
    chk("ramstore", 64'(ramstore), 64'(es));
    chk("iwait", 64'(iwait), 64'(ew_i));
    chk("dwait", 64'(dwait), 64'(ew_d));
    chk("iload", 64'(iload), 64'(el_i));
    chk("dload", 64'(dload), 64'(el_d));
  endtask

  task automatic model_edge();
    bit found;
    bit act;
    int c;
    found = 1'b0;
    if (!nRST) begin
      m_busy = 1'b0;
      m_rr   = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (!found && (iREN[c] | dREN[c] | dWEN[c])) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_core  = c;
          m_data  = dREN[c] | dWEN[c];
          m_write = dWEN[c];
        end
      end
    end else begin
      act = m_data ? (dREN[m_core] | dWEN[m_core]) : iREN[m_core];
      if (!act) m_busy = 1'b0;
      else if (ramstate == ACCESS) begin
        m_busy = 1'b0;
        m_rr   = (m_core + 1) % CPUS;
      end
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    check_cycle();
  endtask

  task automatic advance();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic clear_reqs();
    iREN = '0; dREN = '0; dWEN = '0;
  endtask

  initial begin
    m_busy = 1'b0; m_core = 0; m_data = 1'b0; m_write = 1'b0; m_rr = 0;
    nRST = 1'b0; iREN = '1; dREN = '1; dWEN = '1;
    iaddr = {32'h0000_0204, 32'h0000_0200}; daddr = {32'h0000_0104, 32'h0000_0100};
    dstore = {32'hBBBB_0001, 32'hAAAA_0000}; ramload = '0; ramstate = FREE;

    // Reset with every request raised
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rst_ramREN", 64'(ramREN), 64'd0);
      chk("rst_ramWEN", 64'(ramWEN), 64'd0);
      chk("rst_waits", 64'({iwait, dwait}), 64'hF);
      advance();
    end
    nRST = 1'b1;
    sample();
    advance();
    sample();
    chk("first_grant_wen", 64'(ramWEN), 64'd1);
    chk("first_grant_addr", 64'(ramaddr), 64'h100);
    clear_reqs();
    advance();

    // Single read with two BUSY cycles
    dREN[0] = 1'b1; daddr[31:0] = 32'h40; ramload = 32'hDEAD_BEEF;
    sample();
    advance();
    for (int k = 0; k < 3; k++) begin
      ramstate = (k < 2) ? BUSY : ACCESS;
      sample();
      chk("rd_ren", 64'(ramREN), 64'd1);
      chk("rd_addr", 64'(ramaddr), 64'h40);
      if (k == 2) begin
        chk("rd_dwait0", 64'(dwait[0]), 64'd0);
        chk("rd_dload0", 64'(dload[DW-1:0]), 64'hDEAD_BEEF);
      end
      advance();
    end
    clear_reqs();
    sample();
    chk("rd_idle_ren", 64'(ramREN), 64'd0);
    advance();

    // Round-robin between two instruction streams
    nRST = 1'b0;
    sample();
    advance();
    nRST = 1'b1; iREN = 2'b11; ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      sample();
      for (int c = 0; c < CPUS; c++) if (iwait[c] == 1'b0) order.push_back(c);
      advance();
    end
    chk("rr_count", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < order.size()) chk("rr_order", 64'(order[k]), 64'(k % 2));
    clear_reqs();

    // Data write beats instruction read on the same core
    iREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[63:32] = 32'h80; dstore[63:32] = 32'h1234;
    sample();
    advance();
    sample();
    chk("pri_wen", 64'(ramWEN), 64'd1);
    chk("pri_store", 64'(ramstore), 64'h1234);
    chk("pri_dwait1", 64'(dwait[1]), 64'd0);
    advance();
    dWEN[1] = 1'b0;
    sample();
    advance();
    sample();
    chk("pri_ren", 64'(ramREN), 64'd1);
    chk("pri_iaddr", 64'(ramaddr), 64'h204);
    advance();
    clear_reqs();

    // Abort while BUSY leaves rr in place
    dREN[0] = 1'b1; ramstate = BUSY;
    sample();
    advance();
    sample();
    chk("abort_dwait", 64'(dwait), 64'h3);
    dREN[0] = 1'b0;
    advance();
    dREN = 2'b11; ramstate = ACCESS;
    sample();
    chk("abort_idle_ren", 64'(ramREN), 64'd0);
    advance();
    sample();
    chk("abort_rr_core0", 64'(ramaddr), 64'h40);
    advance();
    dREN[0] = 1'b0;

    // Reset in the middle of a grant
    ramstate = BUSY;
    sample();
    advance();
    sample();
    chk("mrst_ren_before", 64'(ramREN), 64'd1);
    nRST = 1'b0;
    #1;
    chk("mrst_ren_during", 64'(ramREN), 64'd0);
    advance();
    nRST = 1'b1; dREN = 2'b11; ramstate = ACCESS;
    sample();
    advance();
    sample();
    chk("mrst_core0_first", 64'(ramaddr), 64'h40);
    advance();
    clear_reqs();

    // Randomized traffic: cores hold requests until served, occasionally abort
    for (int n = 0; n < 3000; n++) begin
      sample();
      advance();
      nRST = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < CPUS; c++) begin
        if (e_done_i[c]) iREN[c] = 1'b0;
        if (e_done_d[c]) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
        if ((iREN[c] || dREN[c] || dWEN[c]) && $urandom_range(0, 49) == 0) begin
          iREN[c] = 1'b0; dREN[c] = 1'b0; dWEN[c] = 1'b0;
        end
        if (!iREN[c] && $urandom_range(0, 3) == 0) begin
          iREN[c] = 1'b1;
          iaddr[c*AW +: AW] = $urandom;
        end
        if (!dREN[c] && !dWEN[c] && $urandom_range(0, 3) == 0) begin
          dREN[c] = 1'($urandom);
          dWEN[c] = !dREN[c] || ($urandom_range(0, 3) == 0);
          daddr[c*AW +: AW]  = $urandom;
          dstore[c*DW +: DW] = $urandom;
        end
      end
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload  = $urandom;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
